// File: rtl/restoring_divider_seq_if.sv
// Handshake bundle for the restoring divider: operand request side and result side.
interface restoring_divider_seq_if #(
    parameter int DIVIDEND_W = 5,
    parameter int DIVISOR_W  = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/restoring_divider_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, valid/ready on both sides.
module restoring_divider_seq #(
    parameter int DIVIDEND_W = 5,
    parameter int DIVISOR_W  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    restoring_divider_seq_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int             CNT_W    = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIVIDEND_W);

    logic [1:0]            state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [DIVIDEND_W-1:0] quo_q,     quo_d;
    logic [DIVISOR_W:0]    prem_q,    prem_d;
    logic [DIVISOR_W-1:0]  dvs_q,     dvs_d;
    logic [DIVISOR_W-1:0]  rem_q,     rem_d;
    logic                  dbz_q,     dbz_d;

    logic [DIVISOR_W+1:0]  shifted;
    logic [DIVISOR_W+1:0]  trial;
    logic                  neg;

    // Partial remainder stays below the divisor, so DIVISOR_W+2 bits keep the sign honest.
    assign shifted = {prem_q, quo_q[DIVIDEND_W-1]};
    assign trial   = shifted - {2'b00, dvs_q};
    assign neg     = trial[DIVISOR_W+1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        prem_d  = prem_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    quo_d  = bus.dividend;
                    dvs_d  = bus.divisor;
                    prem_d = '0;
                    if (bus.divisor != '0) begin
                        cnt_d   = CNT_INIT;
                        state_d = S_CALC;
                    end else begin
                        quo_d   = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_CALC: begin
                prem_d = neg ? shifted[DIVISOR_W:0] : trial[DIVISOR_W:0];
                quo_d  = (quo_q << 1) | DIVIDEND_W'(!neg);
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    rem_d   = prem_d[DIVISOR_W-1:0];
                    dbz_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            prem_q  <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            prem_q  <= prem_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_divider_seq.sv
// Directed bench for restoring_divider_seq: vector table, exhaustive identity sweep, corner sequences.
module tb_restoring_divider_seq;
    localparam int DW = 5;
    localparam int SW = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    restoring_divider_seq_if #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) bus ();
    restoring_divider_seq #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] dvd;
        logic [SW-1:0] dvs;
        logic [DW-1:0] q;
        logic [SW-1:0] r;
        logic          z;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_in_ready();
        int t = 0;
        while (!bus.in_ready && t < 50) begin tick(); t++; end
        chk("in_ready_wait", int'(bus.in_ready), 1);
    endtask

    // Accept, scramble operands, wait for out_valid, capture, handshake.
    task automatic do_op(input logic [DW-1:0] a, input logic [SW-1:0] b,
                         output logic [DW-1:0] q, output logic [SW-1:0] r,
                         output logic z, output int lat);
        wait_in_ready();
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.dividend = '0;
        bus.divisor  = SW'(1);
        chk("in_ready_drop", int'(bus.in_ready), 0);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin tick(); lat++; end
        chk("out_valid_seen", int'(bus.out_valid), 1);
        q = bus.quotient;
        r = bus.remainder;
        z = bus.div_by_zero;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("out_valid_drop", int'(bus.out_valid), 0);
        chk("in_ready_back", int'(bus.in_ready), 1);
    endtask

    vec_t vecs[11];

    initial begin
        logic [DW-1:0] q;
        logic [SW-1:0] r;
        logic          z;
        int            lat;
        int            t;
        logic          seen;

        vecs[0]  = '{5'd21, 2'd3, 5'd7,  2'd0, 1'b0};
        vecs[1]  = '{5'd20, 2'd3, 5'd6,  2'd2, 1'b0};
        vecs[2]  = '{5'd31, 2'd1, 5'd31, 2'd0, 1'b0};
        vecs[3]  = '{5'd1,  2'd3, 5'd0,  2'd1, 1'b0};
        vecs[4]  = '{5'd5,  2'd0, 5'd31, 2'd0, 1'b1};
        vecs[5]  = '{5'd6,  2'd2, 5'd3,  2'd0, 1'b0};
        vecs[6]  = '{5'd27, 2'd3, 5'd9,  2'd0, 1'b0};
        vecs[7]  = '{5'd31, 2'd3, 5'd10, 2'd1, 1'b0};
        vecs[8]  = '{5'd17, 2'd2, 5'd8,  2'd1, 1'b0};
        vecs[9]  = '{5'd0,  2'd1, 5'd0,  2'd0, 1'b0};
        vecs[10] = '{5'd0,  2'd0, 5'd31, 2'd0, 1'b1};

        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        tick();
        tick();
        chk("rst_in_ready",  int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_quotient",  int'(bus.quotient), 0);
        chk("rst_remainder", int'(bus.remainder), 0);
        chk("rst_dbz",       int'(bus.div_by_zero), 0);

        // Reset beats in_valid in IDLE.
        bus.dividend = 5'd9;
        bus.divisor  = 2'd1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        reset = 1'b0;
        chk("rst_vs_valid_in_ready", int'(bus.in_ready), 1);
        tick();
        chk("rst_vs_valid_out_valid", int'(bus.out_valid), 0);

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].dvd, vecs[i].dvs, q, r, z, lat);
            chk($sformatf("vec%0d_quotient", i),  int'(q), int'(vecs[i].q));
            chk($sformatf("vec%0d_remainder", i), int'(r), int'(vecs[i].r));
            chk($sformatf("vec%0d_dbz", i),       int'(z), int'(vecs[i].z));
            chk($sformatf("vec%0d_latency", i),   lat, vecs[i].z ? 0 : DW);
        end

        for (int a = 0; a < 32; a++) begin
            for (int b = 1; b < 4; b++) begin
                do_op(DW'(a), SW'(b), q, r, z, lat);
                chk($sformatf("sweep_%0d_%0d_identity", a, b), int'(q) * b + int'(r), a);
                chk($sformatf("sweep_%0d_%0d_rem_lt", a, b), int'(int'(r) < b), 1);
            end
        end

        // Backpressure: 14/3 held for 10 cycles, 9/1 pulse ignored.
        wait_in_ready();
        bus.dividend = 5'd14;
        bus.divisor  = 2'd3;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        t = 0;
        while (!bus.out_valid && t < 50) begin tick(); t++; end
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                bus.dividend = 5'd9;
                bus.divisor  = 2'd1;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            chk($sformatf("bp%0d_out_valid", c), int'(bus.out_valid), 1);
            chk($sformatf("bp%0d_quotient", c),  int'(bus.quotient), 4);
            chk($sformatf("bp%0d_remainder", c), int'(bus.remainder), 2);
            chk($sformatf("bp%0d_in_ready", c),  int'(bus.in_ready), 0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_release_in_ready",  int'(bus.in_ready), 1);
        chk("bp_release_out_valid", int'(bus.out_valid), 0);
        chk("bp_release_hold_q",    int'(bus.quotient), 4);

        // Reset on the 3rd CALC edge of 29/2.
        bus.dividend = 5'd29;
        bus.divisor  = 2'd2;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midcalc_in_ready",  int'(bus.in_ready), 1);
        chk("midcalc_out_valid", int'(bus.out_valid), 0);
        chk("midcalc_quotient",  int'(bus.quotient), 0);
        chk("midcalc_remainder", int'(bus.remainder), 0);
        chk("midcalc_dbz",       int'(bus.div_by_zero), 0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin seen |= bus.out_valid; tick(); end
        chk("midcalc_no_result", int'(seen), 0);
        do_op(5'd29, 2'd2, q, r, z, lat);
        chk("after_rst_quotient",  int'(q), 14);
        chk("after_rst_remainder", int'(r), 1);

        // Reset beats out_ready in DONE.
        wait_in_ready();
        bus.dividend = 5'd10;
        bus.divisor  = 2'd3;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        t = 0;
        while (!bus.out_valid && t < 50) begin tick(); t++; end
        chk("done_q_before_rst", int'(bus.quotient), 3);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        reset = 1'b0;
        bus.out_ready = 1'b0;
        chk("done_rst_out_valid", int'(bus.out_valid), 0);
        chk("done_rst_quotient",  int'(bus.quotient), 0);
        chk("done_rst_remainder", int'(bus.remainder), 0);
        chk("done_rst_in_ready",  int'(bus.in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
